// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial S - B subtractor (one full-subtractor cell + borrow flop) with start/done handshake.
// Optional macro SUB_SATURATE_EN: clamp the loaded difference to 0 when the final borrow is set.
module tt_um_serial_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic             start_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] r_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       d_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;
  logic             range_q;

  logic             start_acc;
  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] d_fin;
  logic             unused_bits;

  assign start_acc = ena & uio_in[4] & ~start_q & ((state_q == IDLE) | (state_q == DONE));

  assign d_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_d  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
  assign r_d   = {d_bit, r_q[WIDTH-1:1]};

`ifdef SUB_SATURATE_EN
  assign d_fin = br_d ? '0 : r_d;
`else
  assign d_fin = r_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_q      <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      range_q  <= 1'b0;
    end else if (ena) begin
      start_q <= uio_in[4];
      case (state_q)
        IDLE, DONE: begin
          if (start_acc) begin
            state_q <= SHIFT;
            a_sh_q  <= ui_in[WIDTH-1:0];
            b_sh_q  <= WIDTH'(uio_in[3:0]);
            br_q    <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          r_q    <= r_d;
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          br_q   <= br_d;
          cnt_q  <= cnt_q + 1'b1;
          // Last bit: result registers only change here, so the old result stays visible while shifting.
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            d_q      <= d_fin[3:0];
            borrow_q <= br_d;
            range_q  <= d_fin[WIDTH-1] & ~br_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uo_out      = {range_q, done_q, busy_q, borrow_q, d_q};
  assign uio_out     = 8'h00;
  assign uio_oe      = 8'h00;
  assign unused_bits = ^{ui_in[7:5], uio_in[7:5]};

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Self-checking bench for tt_um_serial_subtractor: vector table, random ops vs arithmetic model, corner sequences.
module tb_tt_um_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_err = 0;

  tt_um_serial_subtractor #(.WIDTH(5)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] s;
    logic [3:0] b;
    logic [3:0] d;
    logic       brw;
    logic       rng;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic on the operand values.
  task automatic model(input int s, input int b, output logic [3:0] d, output logic brw,
                       output logic rng);
    int diff;
    int dm;
    diff = s - b;
    brw  = (diff < 0);
    dm   = (diff + 32) % 32;
`ifdef SUB_SATURATE_EN
    if (brw) dm = 0;
`endif
    d    = dm[3:0];
    rng  = !brw && (dm > 15);
  endtask

  // Launch one op with a one-cycle start pulse; return latency, busy after accept and D mid-shift.
  task automatic run_op(input logic [4:0] s, input logic [3:0] b, output int lat,
                        output logic busy0, output logic [3:0] d_mid);
    @(negedge clk);
    ui_in  = {3'b101, s};
    uio_in = {3'b010, 1'b1, b};
    @(negedge clk);
    uio_in[4] = 1'b0;
    busy0 = uo_out[5];
    d_mid = 4'h0;
    lat   = 0;
    while (!uo_out[6] && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 2) d_mid = uo_out[3:0];
    end
  endtask

  task automatic op_and_check(input string tag, input logic [4:0] s, input logic [3:0] b,
                              input logic [3:0] d, input logic brw, input logic rng,
                              input logic [3:0] prev_d);
    int         lat;
    logic       busy0;
    logic [3:0] d_mid;
    run_op(s, b, lat, busy0, d_mid);
    $display("op %s S=%0d B=%0d -> uo_out=%02h lat=%0d", tag, s, b, uo_out, lat);
    check({tag, " latency"}, lat, 5);
    check({tag, " busy_after_accept"}, int'(busy0), 1);
    check({tag, " D_held_during_shift"}, int'(d_mid), int'(prev_d));
    check({tag, " D"}, int'(uo_out[3:0]), int'(d));
    check({tag, " borrow"}, int'(uo_out[4]), int'(brw));
    check({tag, " range"}, int'(uo_out[7]), int'(rng));
    check({tag, " busy_done"}, int'(uo_out[6:5]), 2);
  endtask

  vec_t       vecs[9];
  logic [3:0] prev_d;
  logic [3:0] md;
  logic       mb;
  logic       mr;
  int         lat;
  int         busy_cnt;
  logic       busy0;
  logic [3:0] d_mid;
  logic [4:0] rs;
  logic [3:0] rb;

  initial begin
`ifdef SUB_SATURATE_EN
    vecs[1] = '{5'd3,  4'd9,  4'h0, 1'b1, 1'b0};
    vecs[7] = '{5'd0,  4'd15, 4'h0, 1'b1, 1'b0};
`else
    vecs[1] = '{5'd3,  4'd9,  4'hA, 1'b1, 1'b0};
    vecs[7] = '{5'd0,  4'd15, 4'h1, 1'b1, 1'b0};
`endif
    vecs[0] = '{5'd18, 4'd7,  4'hB, 1'b0, 1'b0};
    vecs[2] = '{5'd31, 4'd0,  4'hF, 1'b0, 1'b1};
    vecs[3] = '{5'd0,  4'd0,  4'h0, 1'b0, 1'b0};
    vecs[4] = '{5'd9,  4'd4,  4'h5, 1'b0, 1'b0};
    vecs[5] = '{5'd16, 4'd15, 4'h1, 1'b0, 1'b0};
    vecs[6] = '{5'd30, 4'd7,  4'h7, 1'b0, 1'b1};
    vecs[8] = '{5'd15, 4'd15, 4'h0, 1'b0, 1'b0};

    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    repeat (3) @(negedge clk);
    $display("reset: uo_out=%02h uio_out=%02h uio_oe=%02h", uo_out, uio_out, uio_oe);
    check("reset uo_out", int'(uo_out), 0);
    check("reset uio_out", int'(uio_out), 0);
    check("reset uio_oe", int'(uio_oe), 0);
    rst = 1'b0;

    prev_d = 4'h0;
    foreach (vecs[i]) begin
      op_and_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].b, vecs[i].d, vecs[i].brw,
                   vecs[i].rng, prev_d);
      prev_d = vecs[i].d;
    end

    for (int i = 0; i < 30; i++) begin
      rs = 5'($urandom_range(0, 31));
      rb = 4'($urandom_range(0, 15));
      model(int'(rs), int'(rb), md, mb, mr);
      op_and_check($sformatf("rand%0d", i), rs, rb, md, mb, mr, prev_d);
      prev_d = md;
    end

    // Start held high for 20 cycles: exactly one busy period of 5 cycles.
    @(negedge clk);
    ui_in = 8'd18; uio_in = {3'b000, 1'b1, 4'd7};
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uo_out[5]) busy_cnt++;
    end
    uio_in[4] = 1'b0;
    $display("held start: busy_cycles=%0d uo_out=%02h", busy_cnt, uo_out);
    check("held_start busy_cycles", busy_cnt, 5);
    check("held_start done", int'(uo_out[6]), 1);
    check("held_start D", int'(uo_out[3:0]), 11);

    // Reset landing on the 3rd SHIFT edge.
    @(negedge clk);
    ui_in = 8'd20; uio_in = {3'b000, 1'b1, 4'd15};
    @(negedge clk);
    uio_in[4] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("reset mid-shift: uo_out=%02h", uo_out);
    check("rst_mid_shift uo_out", int'(uo_out), 0);
    rst = 1'b0;
    op_and_check("after_rst", 5'd9, 4'd4, 4'd5, 1'b0, 1'b0, 4'h0);

    // ena low for 4 cycles mid-shift plus stray start edges while busy.
    @(negedge clk);
    ui_in = 8'd20; uio_in = {3'b000, 1'b1, 4'd15};
    @(negedge clk);
    uio_in[4] = 1'b0;
    lat = 0;
    @(negedge clk); lat++;
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      uio_in[4] = (i == 1);
      @(negedge clk); lat++;
    end
    uio_in[4] = 1'b0;
    check("ena_low busy_held", int'(uo_out[5]), 1);
    ena = 1'b1;
    @(negedge clk); lat++;
    uio_in[4] = 1'b1;
    @(negedge clk); lat++;
    uio_in[4] = 1'b0;
    while (!uo_out[6] && lat < 30) begin
      @(negedge clk); lat++;
    end
    $display("ena freeze: uo_out=%02h lat=%0d", uo_out, lat);
    check("ena_freeze latency", lat, 9);
    check("ena_freeze D", int'(uo_out[3:0]), 5);
    check("ena_freeze borrow", int'(uo_out[4]), 0);
    repeat (8) @(negedge clk);
    check("ena_freeze no_restart busy", int'(uo_out[5]), 0);
    check("ena_freeze done_kept", int'(uo_out[6]), 1);

    // Back-to-back: a new start accepted the cycle done is seen.
    run_op(5'd31, 4'd0, lat, busy0, d_mid);
    check("b2b latency", lat, 5);
    check("b2b D", int'(uo_out[3:0]), 15);
    check("b2b range", int'(uo_out[7]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
